// File: rtl/main_memory_ctrl.sv
// Block-organised main memory with fixed read/write latency and a valid bit per block.
// One request in flight; responses are a registered one-cycle strobe.
module main_memory_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 11,
    parameter int BLOCK_SIZE    = 32,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
    input  logic                             mem_read,
    input  logic                             mem_write,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_block,
    output logic                             mem_ready,
    output logic                             mem_hit,
    output logic [15:0]                      rd_count,
    output logic [15:0]                      wr_count
);

    localparam int OFFSET_W   = $clog2(BLOCK_SIZE);
    localparam int IDX_W      = ADDR_WIDTH - OFFSET_W;
    localparam int NUM_BLOCKS = 2 ** IDX_W;
    localparam int BLK_W      = BLOCK_SIZE * DATA_WIDTH;

    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESPOND,
        S_RECOVER
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]            r_cnt;
    logic                  r_is_wr;
    logic [IDX_W-1:0]      r_idx;
    logic [BLK_W-1:0]      r_wdata;
    logic [NUM_BLOCKS-1:0] r_valid;
    logic [BLK_W-1:0]      r_mem [NUM_BLOCKS];

    logic       w_accept;
    logic       w_req_wr;
    logic [3:0] w_load;
    logic       w_unused_off;

    assign w_unused_off = ^mem_addr[OFFSET_W-1:0];

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_req_wr = mem_write;
        w_load   = mem_write ? WR_LOAD : RD_LOAD;
        unique case (r_state)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    w_accept = 1'b1;
                    w_next   = (w_load == 4'd0) ? S_RESPOND : S_BUSY;
                end
            end
            // Leave BUSY on the edge where the counter reaches zero.
            S_BUSY: begin
                if (r_cnt <= 4'd1) begin
                    w_next = S_RESPOND;
                end
            end
            S_RESPOND: w_next = S_RECOVER;
            S_RECOVER: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_is_wr        <= 1'b0;
            r_idx          <= '0;
            r_valid        <= '0;
            mem_ready      <= 1'b0;
            mem_hit        <= 1'b0;
            mem_data_block <= '0;
            rd_count       <= '0;
            wr_count       <= '0;
        end else begin
            mem_ready <= 1'b0;
            mem_hit   <= 1'b0;
            if (w_accept) begin
                r_cnt   <= w_load;
                r_is_wr <= w_req_wr;
                r_idx   <= mem_addr[ADDR_WIDTH-1:OFFSET_W];
                if (w_req_wr) begin
                    if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                end else begin
                    if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                end
            end
            if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == S_RESPOND) begin
                mem_ready <= 1'b1;
                if (r_is_wr) begin
                    r_valid[r_idx] <= 1'b1;
                    mem_data_block <= r_wdata;
                    mem_hit        <= 1'b1;
                end else begin
                    mem_data_block <= r_valid[r_idx] ? r_mem[r_idx] : '0;
                    mem_hit        <= r_valid[r_idx];
                end
            end
        end
    end

    // Block contents are not reset; the valid bits alone gate visibility.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wdata <= mem_data_out;
        end
        if (r_state == S_RESPOND && r_is_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl: table of requests plus
// hand-written held-read, dropped-request and mid-request reset sequences.
module tb_main_memory_ctrl;

    localparam int RL = 4;
    localparam int WL = 2;
    localparam int BW = 1024;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [10:0]    mem_addr = '0;
    logic [BW-1:0]  mem_data_out = '0;
    logic           mem_read = 1'b0;
    logic           mem_write = 1'b0;
    logic [BW-1:0]  mem_data_block;
    logic           mem_ready;
    logic           mem_hit;
    logic [15:0]    rd_count;
    logic [15:0]    wr_count;

    main_memory_ctrl #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (11),
        .BLOCK_SIZE   (32),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_addr      (mem_addr),
        .mem_data_out  (mem_data_out),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_data_block(mem_data_block),
        .mem_ready     (mem_ready),
        .mem_hit       (mem_hit),
        .rd_count      (rd_count),
        .wr_count      (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] data;
        logic          hit;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [10:0] addr;
        logic [31:0] wbase;
        logic        ezero;
        logic [31:0] ebase;
        logic        ehit;
        logic [15:0] erd;
        logic [15:0] ewr;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[8];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [BW-1:0] blk(input logic [31:0] base);
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) b[i*32 +: 32] = base + 32'(i);
        return b;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [BW-1:0] act,
                           input logic [BW-1:0] exp);
        int w;
        checks++;
        if (act !== exp) begin
            failures++;
            w = 0;
            for (int i = 31; i >= 0; i--)
                if (act[i*32 +: 32] !== exp[i*32 +: 32]) w = i;
            $display("FAIL %s word%0d act=%0h exp=%0h", nm, w,
                     act[w*32 +: 32], exp[w*32 +: 32]);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mem_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready act=1 exp=0");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk_blk("resp_data", mem_data_block, e.data);
                chk("resp_hit", 64'(mem_hit), 64'(e.hit));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns one cycle after ready.
    task automatic do_req(input logic rd, input logic wr,
                          input logic [10:0] a, input logic [BW-1:0] wd,
                          input logic [BW-1:0] ed, input logic eh,
                          input int lat, input bit inj);
        int k;
        sb_q.push_back('{ed, eh});
        mem_read = rd;
        mem_write = wr;
        mem_addr = a;
        mem_data_out = wd;
        @(negedge clk);
        mem_read = 1'b0;
        mem_write = 1'b0;
        k = 0;
        while (!mem_ready && k < 40) begin
            if (inj && k == 1) begin
                mem_write = 1'b1;
                mem_addr = 11'h300;
                mem_data_out = blk(32'hE000_0000);
            end
            if (inj && k == 2) mem_write = 1'b0;
            @(negedge clk);
            k++;
        end
        chk("latency", 64'(k), 64'(lat));
        @(negedge clk);
        chk("ready_single", 64'(mem_ready), 64'd0);
        chk_blk("data_hold", mem_data_block, ed);
    endtask

    initial begin
        int pulses;
        int last;
        int k;

        tbl[0] = '{1'b1, 1'b0, 11'h040, 32'h0, 1'b1, 32'h0,
                   1'b0, 16'd1, 16'd0};
        tbl[1] = '{1'b0, 1'b1, 11'h0A5, 32'hA000_0000, 1'b0, 32'hA000_0000,
                   1'b1, 16'd1, 16'd1};
        tbl[2] = '{1'b1, 1'b0, 11'h0A0, 32'h0, 1'b0, 32'hA000_0000,
                   1'b1, 16'd2, 16'd1};
        tbl[3] = '{1'b1, 1'b1, 11'h100, 32'hB000_0000, 1'b0, 32'hB000_0000,
                   1'b1, 16'd2, 16'd2};
        tbl[4] = '{1'b1, 1'b0, 11'h11F, 32'h0, 1'b0, 32'hB000_0000,
                   1'b1, 16'd3, 16'd2};
        tbl[5] = '{1'b0, 1'b1, 11'h7E0, 32'hC000_0000, 1'b0, 32'hC000_0000,
                   1'b1, 16'd3, 16'd3};
        tbl[6] = '{1'b1, 1'b0, 11'h7FF, 32'h0, 1'b0, 32'hC000_0000,
                   1'b1, 16'd4, 16'd3};
        tbl[7] = '{1'b1, 1'b0, 11'h0BF, 32'h0, 1'b0, 32'hA000_0000,
                   1'b1, 16'd5, 16'd3};

        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(mem_ready), 64'd0);
        chk("rst_hit", 64'(mem_hit), 64'd0);
        chk("rst_rd", 64'(rd_count), 64'd0);
        chk("rst_wr", 64'(wr_count), 64'd0);
        chk_blk("rst_data", mem_data_block, '0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            do_req(tbl[i].rd, tbl[i].wr, tbl[i].addr, blk(tbl[i].wbase),
                   tbl[i].ezero ? '0 : blk(tbl[i].ebase), tbl[i].ehit,
                   tbl[i].wr ? WL : RL, 1'b0);
            chk("tbl_rd_count", 64'(rd_count), 64'(tbl[i].erd));
            chk("tbl_wr_count", 64'(wr_count), 64'(tbl[i].ewr));
        end

        // Write accepted, reset before its response.
        mem_write = 1'b1;
        mem_addr = 11'h280;
        mem_data_out = blk(32'hF000_0000);
        @(negedge clk);
        mem_write = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(mem_ready), 64'd0);
        chk("arst_rd", 64'(rd_count), 64'd0);
        chk("arst_wr", 64'(wr_count), 64'd0);
        chk_blk("arst_data", mem_data_block, '0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_ready) pulses++;
        end
        chk("arst_no_ready", 64'(pulses), 64'd0);
        do_req(1'b1, 1'b0, 11'h280, '0, '0, 1'b0, RL, 1'b0);
        do_req(1'b1, 1'b0, 11'h0A0, '0, '0, 1'b0, RL, 1'b0);
        chk("arst_rd_after", 64'(rd_count), 64'd2);
        chk("arst_wr_after", 64'(wr_count), 64'd0);

        // Level read held high across three responses.
        for (int i = 0; i < 3; i++) sb_q.push_back('{'0, 1'b0});
        mem_addr = 11'h040;
        mem_read = 1'b1;
        pulses = 0;
        last = 0;
        k = 0;
        while (pulses < 3 && k < 100) begin
            @(negedge clk);
            k++;
            if (mem_ready) begin
                pulses++;
                if (pulses > 1) chk("hold_spacing", 64'(k - last), 64'(RL + 2));
                last = k;
                if (pulses == 3) mem_read = 1'b0;
            end
        end
        chk("hold_pulses", 64'(pulses), 64'd3);
        repeat (10) @(negedge clk);
        chk("hold_rd_count", 64'(rd_count), 64'd5);

        // Write pulse during BUSY is dropped.
        do_req(1'b1, 1'b0, 11'h200, '0, '0, 1'b0, RL, 1'b1);
        chk("drop_wr_count", 64'(wr_count), 64'd0);
        chk("drop_rd_count", 64'(rd_count), 64'd6);
        do_req(1'b1, 1'b0, 11'h300, '0, '0, 1'b0, RL, 1'b0);
        chk("drop_rd_after", 64'(rd_count), 64'd7);

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/main_memory_ctrl.md
MAIN_MEMORY_CTRL -- requirements
Module: main_memory_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bits per word.
REQ-002 Parameter ADDR_WIDTH, default 11, word address width.
REQ-003 Parameter BLOCK_SIZE, default 32, words per block (power of 2); OFFSET_W = log2(BLOCK_SIZE), NUM_BLOCKS = 2^ADDR_WIDTH / BLOCK_SIZE.
REQ-004 Parameter READ_LATENCY, default 4, accept-to-ready cycles for reads (legal range 1..15).
REQ-005 Parameter WRITE_LATENCY, default 2, accept-to-ready cycles for writes (legal range 1..15).
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 mem_addr  input  ADDR_WIDTH  request word address; low OFFSET_W bits ignored (block-aligned).
REQ-009 mem_data_out  input  BLOCK_SIZE*DATA_WIDTH  write block from cache (word i in bits [i*DATA_WIDTH +: DATA_WIDTH]).
REQ-010 mem_read  input  1  read request, level (may stay high after ready).
REQ-011 mem_write  input  1  write request, may be a one-cycle pulse.
REQ-012 mem_data_block  output  BLOCK_SIZE*DATA_WIDTH  response block, registered.
REQ-013 mem_ready  output  1  one-cycle response strobe, registered.
REQ-014 mem_hit  output  1  high with mem_ready when the addressed block has been written since reset.
REQ-015 rd_count  output  16  accepted reads since reset, saturating at 16'hFFFF.
REQ-016 wr_count  output  16  accepted writes since reset, saturating at 16'hFFFF.

Function
REQ-017 Storage SHALL be NUM_BLOCKS blocks of BLOCK_SIZE*DATA_WIDTH bits plus one valid bit per block, indexed by mem_addr[ADDR_WIDTH-1:OFFSET_W].
REQ-018 FSM states: IDLE, BUSY, RESPOND, RECOVER; one request in flight at a time.
REQ-019 IDLE: on edge with mem_write=1 or mem_read=1, latch block index, op (write wins when both high), write data; load counter with latency-1; go to BUSY (or RESPOND directly if latency is 1); increment rd_count or wr_count.
REQ-020 BUSY: decrement counter each cycle; at zero go to RESPOND; request inputs ignored.
REQ-021 Timing: request accepted at edge N SHALL make mem_ready high exactly during the cycle after edge N+LATENCY, low otherwise.
REQ-022 RESPOND edge: mem_ready<=1; read -> mem_data_block<=stored block if valid else all zeros, mem_hit<=valid; write -> store latched data, set valid, mem_data_block<=written data, mem_hit<=1.
REQ-023 RECOVER: one cycle, mem_ready/mem_hit return to 0, inputs ignored, then IDLE; absorbs the held mem_read after ready.
REQ-024 mem_data_block SHALL hold its last value until next response; mem_hit and mem_ready deassert after one cycle.
REQ-025 Requests arriving while not IDLE SHALL be dropped, not queued; a level mem_read still high in IDLE is a new request.
REQ-026 Write then read to same block SHALL return the written data (write committed at its RESPOND edge).
REQ-027 Counters SHALL not wrap at saturation.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, mem_ready=0, mem_hit=0, mem_data_block=0, rd_count=0, wr_count=0, all valid bits 0; block contents need not be cleared.
REQ-029 Reset mid-request SHALL abort it; a pending write SHALL not be committed; first request after rst_n rises is accepted normally.

Verification
REQ-030 Read unwritten block addr 11'h040, READ_LATENCY=4 -> mem_ready single pulse 4 cycles after accept, mem_data_block=0, mem_hit=0, rd_count=1.
REQ-031 Write one-cycle pulse addr 11'h0A5 data words 32'hA000_0000+i -> mem_ready after 2 cycles, mem_hit=1; then read 11'h0A0 -> same data, mem_hit=1.
REQ-032 mem_read held high continuously -> consecutive responses spaced READ_LATENCY+2 cycles, no extra pulses, rd_count increments per response.
REQ-033 mem_read and mem_write both high at 11'h100 -> write performed, wr_count=1, rd_count=0.
REQ-034 Write accepted, rst_n pulsed low before ready -> no mem_ready; subsequent read of that block returns zeros, mem_hit=0.
REQ-035 Request pulse during BUSY -> ignored, exactly one mem_ready, count unchanged by the dropped pulse.
